ysyx_25060170_mem_arb: RTL and testbench
========================================

YSYX_25060170_MEM_ARB -- requirements
Module: ysyx_25060170_mem_arb

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of all address ports.
REQ-002 Parameter DATA_W, default 32, SHALL set the width of all data ports.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (sole clock, rising edge) and rst input 1 (async, active-high).
REQ-004 ifu_req_valid  in  1  fetch request valid.
REQ-005 ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-006 ifu_addr  in  ADDR_W  fetch address.
REQ-007 ifu_resp_valid  out  1  one-cycle pulse carrying instruction data.
REQ-008 ifu_resp_data  out  DATA_W  instruction word.
REQ-009 lsu_req_valid  in  1  load/store request valid.
REQ-010 lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-011 lsu_addr, lsu_wdata  in  ADDR_W/DATA_W  access address and store data.
REQ-012 lsu_wen  in  1  1 = store, 0 = load.
REQ-013 lsu_len  in  3  byte count; legal values 1, 2, 4.
REQ-014 lsu_resp_valid, lsu_resp_err  out  1 each  response pulse and error flag.
REQ-015 lsu_resp_data  out  DATA_W  load data, raw with no extension; 0 for stores.
REQ-016 mem_req_valid, mem_req_ready  out/in  1 each  downstream request handshake.
REQ-017 mem_addr, mem_wdata, mem_wen, mem_len  out  ADDR_W/DATA_W/1/3  latched request fields.
REQ-018 mem_resp_valid, mem_resp_data  in  1/DATA_W  downstream response, including store acks.
REQ-019 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, RESP, ERR, with one outstanding transaction maximum.
REQ-021 IDLE grant rules:
- Only IFU valid: grant IFU.
- Only LSU valid: grant LSU.
- Both valid: grant the requester not granted last; last_owner resets to IFU, so the LSU wins the first tie.
REQ-022 The granted requester's ready SHALL be asserted combinationally in IDLE in the grant cycle; the other requester's ready SHALL be 0; both readies SHALL be 0 outside IDLE.
REQ-023 On grant, the block SHALL latch addr, wdata, wen, len and owner; IFU grants use wen=0 and len=4.
REQ-024 An LSU grant SHALL go to ERR instead of REQ in either case:
- lsu_len is not in {1,2,4};
- lsu_addr is misaligned (len 2 with addr[0]=1, or len 4 with addr[1:0]!=0).
REQ-025 In REQ, mem_req_valid SHALL be 1 with the latched fields held stable until mem_req_ready; the FSM SHALL then go to RESP.
REQ-026 In RESP, on mem_resp_valid, the block SHALL:
- register mem_resp_data;
- pulse the owner's resp_valid for exactly one cycle on the next cycle;
- return to IDLE.
REQ-027 ERR SHALL last one cycle and pulse lsu_resp_valid=1 and lsu_resp_err=1 with lsu_resp_data=0; no memory request SHALL be issued.
REQ-028 Minimum latency: grant at cycle N, mem_req_valid at N+1, resp_valid at N+3 with zero-wait memory; a new grant SHALL be possible in the same cycle as the resp_valid pulse.
REQ-029 mem_resp_valid outside RESP SHALL be ignored.
REQ-030 All resp_valid and resp_err outputs SHALL be 0 except during their defined pulses; resp_data SHALL hold its last value between pulses.

Reset
REQ-031 On rst assertion, regardless of state, the block SHALL:
- force the FSM to IDLE and last_owner to IFU;
- drive all valid, ready, err and busy outputs to 0;
- clear all data, addr and len outputs to 0;
- abandon any outstanding transaction (a later stray mem_resp_valid is ignored by REQ-029).

Structure
REQ-032 Package ysyx_25060170_pkg SHALL hold:
- the state enum;
- the owner encoding (OWN_IFU=0, OWN_LSU=1);
- the LEN_B/LEN_H/LEN_W constants (1/2/4).
REQ-033 Tie-break logic SHALL be a sub-module ysyx_25060170_rr_arb2 (inputs: two requests, last_owner; outputs: grant vector).

Verification
REQ-034 IFU only, addr=0x80000000, memory returns 0x00000413 after 0 wait -> ifu_resp_valid at N+3, data 0x00000413, mem_wen=0, mem_len=4.
REQ-035 Both valid from reset -> LSU granted first; IFU granted on the next IDLE; LSU then granted again on the third tie, proving alternation.
REQ-036 LSU store addr=0x80001002, len=2, wdata=0xBEEF, mem_req_ready held low 3 cycles -> mem fields stable all 4 cycles; lsu_resp_valid=1, err=0 one cycle after the ack.
REQ-037 LSU load addr=0x80001001, len=4 -> no mem_req_valid; lsu_resp_valid=1 and lsu_resp_err=1 at N+1.
REQ-038 rst pulsed while in RESP, then mem_resp_valid arrives -> no resp_valid pulse, busy=0, next IFU request served normally.
REQ-039 mem_resp_valid asserted spuriously in IDLE and in REQ -> no resp_valid pulse and no state change.

Source files
------------

// File: rtl/ysyx_25060170_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
package ysyx_25060170_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    // An LSU access is rejected for an unsupported size or a misaligned address.
    function automatic logic lsu_req_illegal(input logic [2:0] len, input logic [1:0] addr_lo);
        logic bad;
        case (len)
            LEN_B:   bad = 1'b0;
            LEN_H:   bad = addr_lo[0];
            LEN_W:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25060170_mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface ysyx_25060170_mem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_wen;
    logic [2:0]        lsu_len;
    logic              lsu_resp_valid;
    logic              lsu_resp_err;
    logic [DATA_W-1:0] lsu_resp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wen;
    logic [2:0]        mem_len;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    logic              busy;

    modport slave (
        input  ifu_req_valid, ifu_addr,
        input  lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_len,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_resp_data,
        output mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_len,
        output busy
    );

    modport master (
        output ifu_req_valid, ifu_addr,
        output lsu_req_valid, lsu_addr, lsu_wdata, lsu_wen, lsu_len,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_resp_data,
        input  mem_req_valid, mem_addr, mem_wdata, mem_wen, mem_len,
        input  busy
    );

endinterface

// File: rtl/ysyx_25060170_rr_arb2.sv
// Two-way round-robin tie-break between the fetch and load/store requesters.
module ysyx_25060170_rr_arb2
    import ysyx_25060170_pkg::*;
(
    input  logic       i_req_ifu,
    input  logic       i_req_lsu,
    input  owner_e     i_last_owner,
    output logic [1:0] o_grant
);

    // Bit 0 grants the IFU, bit 1 the LSU; on a tie the one not served last wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_req_ifu && i_req_lsu) begin
            if (i_last_owner == OWN_IFU) begin
                o_grant[1] = 1'b1;
            end else begin
                o_grant[0] = 1'b1;
            end
        end else if (i_req_ifu) begin
            o_grant[0] = 1'b1;
        end else if (i_req_lsu) begin
            o_grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_25060170_mem_arb.sv
// Single-outstanding memory arbiter sharing one memory port between IFU and LSU.
// Bad LSU accesses are answered locally with an error pulse and never reach memory.
module ysyx_25060170_mem_arb
    import ysyx_25060170_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_25060170_mem_arb_if.slave  bus
);

    state_e            r_state;
    state_e            w_next_state;
    owner_e            r_owner;
    owner_e            r_last_owner;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wen;
    logic [2:0]        r_len;

    logic              r_ifu_resp_valid;
    logic [DATA_W-1:0] r_ifu_resp_data;
    logic              r_lsu_resp_valid;
    logic              r_lsu_resp_err;
    logic [DATA_W-1:0] r_lsu_resp_data;

    logic [1:0]        w_grant;
    logic              w_is_idle;
    logic              w_grant_ifu;
    logic              w_grant_lsu;
    logic              w_lsu_bad;
    logic              w_mem_req_valid;
    logic              w_busy;
    logic              w_resp_fire;
    logic              w_err_fire;

    ysyx_25060170_rr_arb2 u_rr_arb2 (
        .i_req_ifu    (bus.ifu_req_valid),
        .i_req_lsu    (bus.lsu_req_valid),
        .i_last_owner (r_last_owner),
        .o_grant      (w_grant)
    );

    assign w_is_idle   = (r_state == ST_IDLE);
    assign w_grant_ifu = w_is_idle && !rst && w_grant[0];
    assign w_grant_lsu = w_is_idle && !rst && w_grant[1];
    assign w_lsu_bad   = lsu_req_illegal(bus.lsu_len, bus.lsu_addr[1:0]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: grant from IDLE, wait for the memory handshakes, ERR is a single cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_lsu) begin
                    w_next_state = w_lsu_bad ? ST_ERR : ST_REQ;
                end else if (w_grant_ifu) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.mem_resp_valid) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ERR:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-state outputs and the single-cycle events that feed the response registers.
    always_comb begin
        w_mem_req_valid = (r_state == ST_REQ);
        w_busy          = !w_is_idle;
        w_resp_fire     = (r_state == ST_RESP) && bus.mem_resp_valid;
        w_err_fire      = w_grant_lsu && w_lsu_bad;
    end

    // Capture the winning request so the memory side sees stable fields until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_len        <= 3'd0;
            r_owner      <= OWN_IFU;
            r_last_owner <= OWN_IFU;
        end else if (w_grant_lsu) begin
            r_addr       <= bus.lsu_addr;
            r_wdata      <= bus.lsu_wdata;
            r_wen        <= bus.lsu_wen;
            r_len        <= bus.lsu_len;
            r_owner      <= OWN_LSU;
            r_last_owner <= OWN_LSU;
        end else if (w_grant_ifu) begin
            r_addr       <= bus.ifu_addr;
            r_wdata      <= '0;
            r_wen        <= 1'b0;
            r_len        <= LEN_W;
            r_owner      <= OWN_IFU;
            r_last_owner <= OWN_IFU;
        end
    end

    // Register response pulses and data; data holds between pulses, stores and errors return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ifu_resp_valid <= 1'b0;
            r_ifu_resp_data  <= '0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_err   <= 1'b0;
            r_lsu_resp_data  <= '0;
        end else begin
            r_ifu_resp_valid <= w_resp_fire && (r_owner == OWN_IFU);
            r_lsu_resp_valid <= (w_resp_fire && (r_owner == OWN_LSU)) || w_err_fire;
            r_lsu_resp_err   <= w_err_fire;
            if (w_resp_fire && (r_owner == OWN_IFU)) begin
                r_ifu_resp_data <= bus.mem_resp_data;
            end
            if (w_resp_fire && (r_owner == OWN_LSU)) begin
                r_lsu_resp_data <= r_wen ? '0 : bus.mem_resp_data;
            end else if (w_err_fire) begin
                r_lsu_resp_data <= '0;
            end
        end
    end

    assign bus.ifu_req_ready  = w_grant_ifu;
    assign bus.lsu_req_ready  = w_grant_lsu;
    assign bus.ifu_resp_valid = r_ifu_resp_valid;
    assign bus.ifu_resp_data  = r_ifu_resp_data;
    assign bus.lsu_resp_valid = r_lsu_resp_valid;
    assign bus.lsu_resp_err   = r_lsu_resp_err;
    assign bus.lsu_resp_data  = r_lsu_resp_data;
    assign bus.mem_req_valid  = w_mem_req_valid;
    assign bus.mem_addr       = r_addr;
    assign bus.mem_wdata      = r_wdata;
    assign bus.mem_wen        = r_wen;
    assign bus.mem_len        = r_len;
    assign bus.busy           = w_busy;

endmodule

// File: tb/tb_ysyx_25060170_mem_arb.sv
// Directed and randomized bench for the memory arbiter with a transaction-level model.
module tb_ysyx_25060170_mem_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_25060170_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_25060170_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state: who was granted last, and the last data each requester saw.
    bit          lastLsu    = 1'b0;
    logic [31:0] expIfuData = 32'h0;
    logic [31:0] expLsuData = 32'h0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idleCheck(input string tag);
        checkOutput({tag, "_ifu_rv"}, bus.ifu_resp_valid, 0);
        checkOutput({tag, "_lsu_rv"}, bus.lsu_resp_valid, 0);
        checkOutput({tag, "_lsu_err"}, bus.lsu_resp_err, 0);
        checkOutput({tag, "_busy"}, bus.busy, 0);
        checkOutput({tag, "_mem_rv"}, bus.mem_req_valid, 0);
        checkOutput({tag, "_ifu_data"}, bus.ifu_resp_data, expIfuData);
        checkOutput({tag, "_lsu_data"}, bus.lsu_resp_data, expLsuData);
    endtask

    function automatic bit lsuLegal(input logic [31:0] addr, input logic [2:0] len);
        return (len == 3'd1) || (len == 3'd2 && (addr % 2) == 0) || (len == 3'd4 && (addr % 4) == 0);
    endfunction

    // One complete transaction from the IDLE grant cycle through the response pulse.
    task automatic applyStimulus(input bit ifuV, input logic [31:0] ifuA,
                                 input bit lsuV, input logic [31:0] lsuA, input logic [31:0] lsuWd,
                                 input bit lsuWen, input logic [2:0] lsuLen,
                                 input int readyWait, input int respWait,
                                 input logic [31:0] memData, input bit spur);
        bit winLsu;
        bit isBad;
        winLsu = (ifuV && lsuV) ? !lastLsu : lsuV;
        isBad  = winLsu && !lsuLegal(lsuA, lsuLen);

        bus.ifu_req_valid = ifuV;
        bus.ifu_addr      = ifuA;
        bus.lsu_req_valid = lsuV;
        bus.lsu_addr      = lsuA;
        bus.lsu_wdata     = lsuWd;
        bus.lsu_wen       = lsuWen;
        bus.lsu_len       = lsuLen;
        #1;
        checkOutput("ifu_ready", bus.ifu_req_ready, ifuV && !winLsu);
        checkOutput("lsu_ready", bus.lsu_req_ready, winLsu);
        checkOutput("grant_busy", bus.busy, 0);
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        lastLsu = winLsu;

        if (isBad) begin
            expLsuData = 32'h0;
            checkOutput("err_valid", bus.lsu_resp_valid, 1);
            checkOutput("err_flag", bus.lsu_resp_err, 1);
            checkOutput("err_data", bus.lsu_resp_data, 0);
            checkOutput("err_no_mem", bus.mem_req_valid, 0);
            checkOutput("err_ifu_rv", bus.ifu_resp_valid, 0);
            @(negedge clk);
            idleCheck("after_err");
        end else begin
            for (int w = 0; w <= readyWait; w++) begin
                checkOutput("req_valid", bus.mem_req_valid, 1);
                checkOutput("req_addr", bus.mem_addr, winLsu ? lsuA : ifuA);
                checkOutput("req_wen", bus.mem_wen, winLsu ? lsuWen : 1'b0);
                checkOutput("req_len", bus.mem_len, winLsu ? lsuLen : 3'd4);
                if (winLsu) checkOutput("req_wdata", bus.mem_wdata, lsuWd);
                checkOutput("req_ready_lo", bus.ifu_req_ready | bus.lsu_req_ready, 0);
                checkOutput("req_no_pulse", bus.ifu_resp_valid | bus.lsu_resp_valid, 0);
                bus.mem_req_ready  = (w == readyWait);
                bus.mem_resp_valid = spur && (w < readyWait);
                bus.mem_resp_data  = ~memData;
                @(negedge clk);
                bus.mem_req_ready  = 1'b0;
                bus.mem_resp_valid = 1'b0;
            end
            for (int r = 0; r <= respWait; r++) begin
                checkOutput("resp_mem_rv", bus.mem_req_valid, 0);
                checkOutput("resp_busy", bus.busy, 1);
                checkOutput("resp_no_pulse", bus.ifu_resp_valid | bus.lsu_resp_valid, 0);
                bus.mem_resp_valid = (r == respWait);
                bus.mem_resp_data  = memData;
                @(negedge clk);
                bus.mem_resp_valid = 1'b0;
            end
            if (winLsu) expLsuData = lsuWen ? 32'h0 : memData;
            else        expIfuData = memData;
            checkOutput("pulse_ifu_rv", bus.ifu_resp_valid, !winLsu);
            checkOutput("pulse_lsu_rv", bus.lsu_resp_valid, winLsu);
            checkOutput("pulse_err", bus.lsu_resp_err, 0);
            checkOutput("pulse_ifu_data", bus.ifu_resp_data, expIfuData);
            checkOutput("pulse_lsu_data", bus.lsu_resp_data, expLsuData);
            checkOutput("pulse_busy", bus.busy, 0);
            bus.ifu_req_valid = 1'b1;
            #1;
            checkOutput("pulse_regrant", bus.ifu_req_ready, 1);
            bus.ifu_req_valid = 1'b0;
            @(negedge clk);
            idleCheck("after_resp");
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] lens [8];
        bit          ifuV;
        bit          lsuV;
        lens = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd2, 3'd1};

        bus.ifu_req_valid  = 1'b1;
        bus.ifu_addr       = 32'h0;
        bus.lsu_req_valid  = 1'b1;
        bus.lsu_addr       = 32'h0;
        bus.lsu_wdata      = 32'h0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_len        = 3'd4;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;

        // Reset: readies must stay low even with both requests raised.
        repeat (2) @(negedge clk);
        checkOutput("rst_ifu_ready", bus.ifu_req_ready, 0);
        checkOutput("rst_lsu_ready", bus.lsu_req_ready, 0);
        checkOutput("rst_mem_addr", bus.mem_addr, 0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        checkOutput("rst_mem_len", bus.mem_len, 0);
        checkOutput("rst_mem_wen", bus.mem_wen, 0);
        idleCheck("rst");
        bus.ifu_req_valid = 1'b0;
        bus.lsu_req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Ties alternate starting with the LSU.
        applyStimulus(1, 32'h80000000, 1, 32'h80002000, 32'h11111111, 1, 3'd4, 0, 0, 32'hAAAA0001, 0);
        applyStimulus(1, 32'h80000004, 1, 32'h80002004, 32'h0, 0, 3'd4, 0, 0, 32'hAAAA0002, 0);
        applyStimulus(1, 32'h80000008, 1, 32'h80002008, 32'h0, 0, 3'd2, 0, 0, 32'hAAAA0003, 0);

        // Zero-wait instruction fetch.
        applyStimulus(1, 32'h80000000, 0, 32'h0, 32'h0, 0, 3'd4, 0, 0, 32'h00000413, 0);

        // Halfword store with a back-pressured memory.
        applyStimulus(0, 32'h0, 1, 32'h80001002, 32'h0000BEEF, 1, 3'd2, 3, 0, 32'h12345678, 0);

        // Misaligned word load is answered with an error.
        applyStimulus(0, 32'h0, 1, 32'h80001001, 32'h0, 0, 3'd4, 0, 0, 32'h0, 0);

        // Stray memory responses in IDLE and in REQ are ignored.
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hFEEDFACE;
        repeat (2) begin
            @(negedge clk);
            idleCheck("spur_idle");
        end
        bus.mem_resp_valid = 1'b0;
        applyStimulus(1, 32'h80000100, 0, 32'h0, 32'h0, 0, 3'd4, 2, 1, 32'h5555AAAA, 1);

        // Reset while waiting for the memory response abandons the transaction.
        bus.ifu_req_valid = 1'b1;
        bus.ifu_addr      = 32'h80000040;
        @(negedge clk);
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        checkOutput("resp_state_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        lastLsu    = 1'b0;
        expIfuData = 32'h0;
        expLsuData = 32'h0;
        checkOutput("midrst_mem_addr", bus.mem_addr, 0);
        checkOutput("midrst_mem_len", bus.mem_len, 0);
        idleCheck("midrst");
        @(negedge clk);
        rst = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEADBEEF;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        idleCheck("post_rst_stray");
        applyStimulus(1, 32'h80000044, 0, 32'h0, 32'h0, 0, 3'd4, 0, 0, 32'h00100093, 0);

        // Randomized mix of requesters, sizes, alignments and memory wait states.
        for (int i = 0; i < 60; i++) begin
            ifuV = 1'($urandom_range(0, 1));
            lsuV = 1'($urandom_range(0, 1));
            if (!ifuV && !lsuV) ifuV = 1'b1;
            applyStimulus(ifuV, $urandom & 32'hFFFFFFFC, lsuV, $urandom, $urandom,
                          1'($urandom_range(0, 1)), lens[$urandom_range(0, 7)],
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                idleCheck("rand_gap");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
